// File: rtl/cfs_rx_ctrl.sv
// cfs_rx_ctrl: MD responder on the aligner RX side; checks offset/size legality and
// pushes legal transfers into the RX FIFO. Define CFS_RX_CTRL_DROP_CNT_EN to build the drop counter.
module cfs_rx_ctrl #(
   parameter  int unsigned ALGN_DATA_WIDTH   = 32,
   localparam int unsigned ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8),
   localparam int unsigned ALGN_SIZE_WIDTH   = $clog2(ALGN_DATA_WIDTH / 8) + 1,
   localparam int unsigned FIFO_DATA_WIDTH   = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         md_rx_valid,
   input  logic [ALGN_DATA_WIDTH-1:0]   md_rx_data,
   input  logic [ALGN_OFFSET_WIDTH-1:0] md_rx_offset,
   input  logic [ALGN_SIZE_WIDTH-1:0]   md_rx_size,
   output logic                         md_rx_ready,
   output logic                         md_rx_err,
   output logic                         push_valid,
   output logic [FIFO_DATA_WIDTH-1:0]   push_data,
   input  logic                         push_ready,
   input  logic                         cnt_drop_clr,
   output logic [7:0]                   cnt_drop
);

   // Two spare bits so BYTES+offset and offset+size never wrap.
   localparam int unsigned CW = ALGN_SIZE_WIDTH + 2;
   localparam logic [CW-1:0] BYTES = CW'(ALGN_DATA_WIDTH / 8);

   typedef enum logic [1:0] {
      IDLE,
      ACK,
      PUSH
   } state_t;

   state_t                       state_q, state_d;
   logic                         md_rx_ready_q, md_rx_ready_d;
   logic                         md_rx_err_q, md_rx_err_d;
   logic                         push_valid_q, push_valid_d;
   logic [FIFO_DATA_WIDTH-1:0]   push_data_q, push_data_d;

   logic [CW-1:0] off_w, size_w, div_w;
   logic          legal;

   always_comb begin
      off_w  = CW'(md_rx_offset);
      size_w = CW'(md_rx_size);
      div_w  = (size_w == '0) ? CW'(1) : size_w;
      legal  = (size_w != '0) &&
               ((off_w + size_w) <= BYTES) &&
               (((BYTES + off_w) % div_w) == '0);
   end

   always_comb begin
      state_d       = state_q;
      md_rx_ready_d = 1'b0;
      md_rx_err_d   = 1'b0;
      push_valid_d  = push_valid_q;
      push_data_d   = push_data_q;
      case (state_q)
         IDLE: begin
            if (md_rx_valid) begin
               push_data_d   = {md_rx_size, md_rx_offset, md_rx_data};
               md_rx_ready_d = 1'b1;
               md_rx_err_d   = ~legal;
               state_d       = ACK;
            end
         end
         ACK: begin
            if (md_rx_err_q) begin
               state_d = IDLE;
            end else begin
               push_valid_d = 1'b1;
               state_d      = PUSH;
            end
         end
         PUSH: begin
            if (push_ready) begin
               push_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            push_valid_d = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         md_rx_ready_q <= 1'b0;
         md_rx_err_q   <= 1'b0;
         push_valid_q  <= 1'b0;
         push_data_q   <= '0;
      end else begin
         state_q       <= state_d;
         md_rx_ready_q <= md_rx_ready_d;
         md_rx_err_q   <= md_rx_err_d;
         push_valid_q  <= push_valid_d;
         push_data_q   <= push_data_d;
      end
   end

   assign md_rx_ready = md_rx_ready_q;
   assign md_rx_err   = md_rx_err_q;
   assign push_valid  = push_valid_q;
   assign push_data   = push_data_q;

`ifdef CFS_RX_CTRL_DROP_CNT_EN
   logic [7:0] cnt_drop_q, cnt_drop_d;
   logic       drop_inc;

   // A clear coinciding with a drop leaves that drop counted.
   always_comb begin
      drop_inc   = (state_q == ACK) && md_rx_err_q;
      cnt_drop_d = cnt_drop_q;
      if (cnt_drop_clr) begin
         cnt_drop_d = drop_inc ? 8'd1 : 8'd0;
      end else if (drop_inc && (cnt_drop_q != '1)) begin
         cnt_drop_d = cnt_drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_drop_q <= '0;
      end else begin
         cnt_drop_q <= cnt_drop_d;
      end
   end

   assign cnt_drop = cnt_drop_q;
`else
   logic unused_cnt_drop_clr;
   assign unused_cnt_drop_clr = cnt_drop_clr;
   assign cnt_drop            = '0;
`endif

endmodule

// File: tb/tb_cfs_rx_ctrl.sv
// Self-checking bench for cfs_rx_ctrl (BYTES=4); the drop-count model follows
// CFS_RX_CTRL_DROP_CNT_EN so the same bench covers both builds.
module tb_cfs_rx_ctrl;

   localparam int DW    = 32;
   localparam int OW    = 2;
   localparam int SW    = 3;
   localparam int FW    = DW + OW + SW;
   localparam int BYTES = DW / 8;
`ifdef CFS_RX_CTRL_DROP_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          md_rx_valid;
   logic [DW-1:0] md_rx_data;
   logic [OW-1:0] md_rx_offset;
   logic [SW-1:0] md_rx_size;
   logic          md_rx_ready;
   logic          md_rx_err;
   logic          push_valid;
   logic [FW-1:0] push_data;
   logic          push_ready;
   logic          cnt_drop_clr;
   logic [7:0]    cnt_drop;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   cfs_rx_ctrl #(.ALGN_DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .md_rx_valid  (md_rx_valid),
      .md_rx_data   (md_rx_data),
      .md_rx_offset (md_rx_offset),
      .md_rx_size   (md_rx_size),
      .md_rx_ready  (md_rx_ready),
      .md_rx_err    (md_rx_err),
      .push_valid   (push_valid),
      .push_data    (push_data),
      .push_ready   (push_ready),
      .cnt_drop_clr (cnt_drop_clr),
      .cnt_drop     (cnt_drop)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1);
   end

   function automatic bit is_legal(input int off, input int sz);
      if (sz == 0) return 1'b0;
      if (off + sz > BYTES) return 1'b0;
      return ((BYTES + off) % sz) == 0;
   endfunction

   function automatic int cnt_next(input int c, input bit inc, input bit clr);
      if (!CNT_EN) return 0;
      if (clr) return inc ? 1 : 0;
      if (inc) return (c < 255) ? c + 1 : 255;
      return c;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transfer: request, ACK, optional push with `stall` cycles of backpressure.
   task automatic xfer(input logic [DW-1:0] d, input int off, input int sz,
                       input int stall, input bit clr_in_ack);
      logic [FW-1:0] exp_pd;
      bit            lg;
      lg           = is_legal(off, sz);
      exp_pd       = {SW'(sz), OW'(off), d};
      md_rx_valid  = 1'b1;
      md_rx_data   = d;
      md_rx_offset = OW'(off);
      md_rx_size   = SW'(sz);
      step();
      md_rx_valid  = 1'b0;
      chk("ack_ready", 64'(md_rx_ready), 64'd1);
      chk("ack_err",   64'(md_rx_err),   64'(!lg));
      chk("ack_pv",    64'(push_valid),  64'd0);
      cnt_drop_clr = clr_in_ack;
      push_ready   = (stall == 0);
      exp_cnt      = cnt_next(exp_cnt, !lg, clr_in_ack);
      step();
      cnt_drop_clr = 1'b0;
      chk("post_ack_ready", 64'(md_rx_ready), 64'd0);
      chk("post_ack_err",   64'(md_rx_err),   64'd0);
      if (lg) begin
         for (int i = 0; i < stall; i++) begin
            chk("stall_pv",    64'(push_valid),  64'd1);
            chk("stall_pd",    64'(push_data),   64'(exp_pd));
            chk("stall_ready", 64'(md_rx_ready), 64'd0);
            step();
         end
         push_ready = 1'b1;
         chk("push_pv", 64'(push_valid), 64'd1);
         chk("push_pd", 64'(push_data),  64'(exp_pd));
         step();
         chk("after_push_pv", 64'(push_valid), 64'd0);
      end else begin
         chk("drop_no_pv", 64'(push_valid), 64'd0);
      end
      chk("cnt_drop", 64'(cnt_drop), 64'(exp_cnt));
   endtask

   initial begin
      int off, sz, n_ill;
      int ill_off[4];
      int ill_sz[4];
      logic [DW-1:0] d1, d2;
      logic [FW-1:0] e1, e2;

      reset        = 1'b1;
      md_rx_valid  = 1'b0;
      md_rx_data   = '0;
      md_rx_offset = '0;
      md_rx_size   = '0;
      push_ready   = 1'b1;
      cnt_drop_clr = 1'b0;
      step();
      step();
      chk("rst_ready", 64'(md_rx_ready), 64'd0);
      chk("rst_err",   64'(md_rx_err),   64'd0);
      chk("rst_pv",    64'(push_valid),  64'd0);
      chk("rst_pd",    64'(push_data),   64'd0);
      chk("rst_cnt",   64'(cnt_drop),    64'd0);
      reset = 1'b0;
      step();
      chk("idle_ready", 64'(md_rx_ready), 64'd0);

      xfer(32'hAABBCCDD, 0, 4, 0, 1'b0);

      ill_off = '{1, 0, 3, 0};
      ill_sz  = '{2, 3, 2, 0};
      for (int i = 0; i < 4; i++) xfer($urandom, ill_off[i], ill_sz[i], 0, 1'b0);

      // Backpressure with a second request waiting behind the push.
      d1 = $urandom;
      d2 = $urandom;
      e1 = {3'd2, 2'd2, d1};
      e2 = {3'd1, 2'd1, d2};
      md_rx_valid  = 1'b1;
      md_rx_data   = d1;
      md_rx_offset = 2'd2;
      md_rx_size   = 3'd2;
      step();
      chk("bp_ack_ready", 64'(md_rx_ready), 64'd1);
      chk("bp_ack_err",   64'(md_rx_err),   64'd0);
      md_rx_data   = d2;
      md_rx_offset = 2'd1;
      md_rx_size   = 3'd1;
      push_ready   = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_pv",    64'(push_valid),  64'd1);
         chk("bp_pd",    64'(push_data),   64'(e1));
         chk("bp_ready", 64'(md_rx_ready), 64'd0);
         step();
      end
      push_ready = 1'b1;
      chk("bp_pv_last", 64'(push_valid), 64'd1);
      chk("bp_pd_last", 64'(push_data),  64'(e1));
      step();
      chk("bp_idle_pv",    64'(push_valid),  64'd0);
      chk("bp_idle_ready", 64'(md_rx_ready), 64'd0);
      step();
      chk("bp2_ack_ready", 64'(md_rx_ready), 64'd1);
      chk("bp2_ack_err",   64'(md_rx_err),   64'd0);
      md_rx_valid = 1'b0;
      step();
      chk("bp2_pv", 64'(push_valid), 64'd1);
      chk("bp2_pd", 64'(push_data),  64'(e2));
      step();
      chk("bp2_done_pv", 64'(push_valid), 64'd0);
      chk("bp_cnt",      64'(cnt_drop),   64'(exp_cnt));

      // 260 random illegal transfers drive the counter into saturation.
      n_ill = 0;
      while (n_ill < 260) begin
         off = $urandom_range(0, 3);
         sz  = $urandom_range(0, 7);
         if (!is_legal(off, sz)) begin
            xfer($urandom, off, sz, 0, 1'b0);
            n_ill++;
         end
      end
      chk("sat_cnt", 64'(cnt_drop), CNT_EN ? 64'd255 : 64'd0);

      cnt_drop_clr = 1'b1;
      step();
      cnt_drop_clr = 1'b0;
      exp_cnt = cnt_next(exp_cnt, 1'b0, 1'b1);
      chk("clr_alone", 64'(cnt_drop), 64'(exp_cnt));
      xfer($urandom, 0, 4, 0, 1'b0);
      xfer($urandom, 1, 1, 0, 1'b0);
      xfer($urandom, 3, 2, 0, 1'b0);
      xfer($urandom, 2, 3, 0, 1'b0);
      cnt_drop_clr = 1'b1;
      step();
      cnt_drop_clr = 1'b0;
      exp_cnt = cnt_next(exp_cnt, 1'b0, 1'b1);
      chk("clr_alone2", 64'(cnt_drop), 64'(exp_cnt));
      xfer($urandom, 0, 0, 0, 1'b1);
      chk("clr_with_inc", 64'(cnt_drop), CNT_EN ? 64'd1 : 64'd0);

      // Reset while stalled in PUSH discards the held transfer.
      md_rx_valid  = 1'b1;
      md_rx_data   = $urandom;
      md_rx_offset = 2'd0;
      md_rx_size   = 3'd2;
      step();
      md_rx_valid = 1'b0;
      push_ready  = 1'b0;
      chk("rstp_ack", 64'(md_rx_ready), 64'd1);
      step();
      chk("rstp_pv", 64'(push_valid), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_cnt = 0;
      chk("rstp_ready", 64'(md_rx_ready), 64'd0);
      chk("rstp_err",   64'(md_rx_err),   64'd0);
      chk("rstp_pv0",   64'(push_valid),  64'd0);
      chk("rstp_pd",    64'(push_data),   64'd0);
      chk("rstp_cnt",   64'(cnt_drop),    64'd0);
      step();
      chk("rstp_pv1", 64'(push_valid), 64'd0);
      push_ready = 1'b1;
      xfer(32'hAABBCCDD, 0, 4, 0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         off = $urandom_range(0, 3);
         sz  = $urandom_range(0, 7);
         xfer($urandom, off, sz, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
